// File: rtl/sub_16_serial.sv
// Bit-serial 16-bit subtractor: diff = a - b, one bit per clock LSB first,
// using a single full-adder slice with b inverted and an initial carry of 1.
module sub_16_serial (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] diff,
  output logic        borrow,
  output logic        zr,
  output logic        ng,
  output logic        ovf
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [15:0] a_sh_r;
  logic [15:0] nb_sh_r;
  logic [15:0] res_sh_r;
  logic [3:0]  cnt_r;
  logic        carry_r;
  logic        sum_s;
  logic        cout_s;
  logic [15:0] diff_fin_s;
  logic        last_bit_s;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // Full-adder slice and the assembled final result on the last shift
  always_comb begin
    sum_s      = a_sh_r[0] ^ nb_sh_r[0] ^ carry_r;
    cout_s     = maj3(a_sh_r[0], nb_sh_r[0], carry_r);
    diff_fin_s = {sum_s, res_sh_r[15:1]};
    last_bit_s = (cnt_r == 4'd15);
  end

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid && in_ready) state_nxt_s = ST_SHIFT;
        else                      state_nxt_s = ST_IDLE;
      end
      ST_SHIFT: begin
        if (last_bit_s) state_nxt_s = ST_DONE;
        else            state_nxt_s = ST_SHIFT;
      end
      ST_DONE: begin
        if (out_ready) state_nxt_s = ST_IDLE;
        else           state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register with handshake outputs registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      in_ready  <= (state_nxt_s == ST_IDLE);
      out_valid <= (state_nxt_s == ST_DONE);
    end
  end

  // Operand/result shift registers, carry, counter and registered flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_r   <= 16'h0000;
      nb_sh_r  <= 16'h0000;
      res_sh_r <= 16'h0000;
      cnt_r    <= 4'd0;
      carry_r  <= 1'b0;
      diff     <= 16'h0000;
      borrow   <= 1'b0;
      zr       <= 1'b0;
      ng       <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            a_sh_r  <= a;
            nb_sh_r <= ~b;
            carry_r <= 1'b1;
            cnt_r   <= 4'd0;
          end
        end
        ST_SHIFT: begin
          a_sh_r   <= {1'b0, a_sh_r[15:1]};
          nb_sh_r  <= {1'b0, nb_sh_r[15:1]};
          res_sh_r <= diff_fin_s;
          carry_r  <= cout_s;
          cnt_r    <= cnt_r + 4'd1;
          // On the last bit the shift registers hold a[15] and ~b[15] at bit 0
          if (last_bit_s) begin
            diff   <= diff_fin_s;
            borrow <= ~cout_s;
            zr     <= (diff_fin_s == 16'h0000);
            ng     <= sum_s;
            ovf    <= (a_sh_r[0] == nb_sh_r[0]) && (sum_s != a_sh_r[0]);
          end
        end
        ST_DONE: begin
          carry_r <= carry_r;
        end
        default: begin
          cnt_r <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/sub_16_serial.md
# sub_16_serial

Bit-serial 16-bit subtractor computing `diff = a - b` one bit per clock, LSB first. It uses a single full-adder slice with `b` inverted and an initial carry of 1. It is the sequential, area-minimal counterpart to the 16-bit ripple adder in the arithmetic library, intended for datapaths that trade latency for gate count. Operands enter and results leave through valid/ready handshakes. The result is accompanied by borrow, zero, negative and signed-overflow flags.

## Interface
- No parameters; width is fixed at 16.
- `clk` input 1: single clock, all state updates on rising edge.
- `rst_n` input 1: asynchronous active-low reset; asserts immediately, deasserts synchronously to `clk`.
- `in_valid` input 1: operands `a`, `b` valid.
- `in_ready` output 1: block can accept operands; high only in IDLE.
- `a` input 16: minuend.
- `b` input 16: subtrahend.
- `out_valid` output 1: `diff` and flags valid.
- `out_ready` input 1: consumer accepts the result.
- `diff` output 16: `a - b` mod 2^16.
- `borrow` output 1: 1 when `a < b` unsigned, i.e. NOT of the final carry.
- `zr` output 1: 1 when `diff == 16'h0000`.
- `ng` output 1: equals `diff[15]`.
- `ovf` output 1: signed overflow, `(a[15] != b[15]) && (diff[15] != a[15])`.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: `in_ready = 1`. On an edge with `in_valid && in_ready`:
  - latch `a` and `~b` into shift registers;
  - set carry = 1 and bit counter = 0;
  - go to SHIFT.
- SHIFT, each edge:
  - sum = a_sh[0] ^ nb_sh[0] ^ carry;
  - carry = majority(a_sh[0], nb_sh[0], carry);
  - shift sum into result MSB, shift result, a_sh and nb_sh right by one;
  - counter += 1.
  - On the edge where counter == 15, go to DONE. On that same edge, register the final `diff`, `borrow = ~carry_out`, `zr`, `ng` and `ovf`. `ovf` uses latched `a[15]` and `b[15]`.
- DONE: `out_valid = 1`. Outputs are held stable while `out_ready = 0`. On an edge with `out_valid && out_ready`, go to IDLE.
- `diff` and the flags are registered. They keep their last value after the handshake, until the next result or reset.
- Input values of `a`/`b` outside the acceptance edge are ignored. Changes during SHIFT or DONE have no effect.
- `in_ready` is low during SHIFT and DONE. A new operand is never accepted on the same edge a result drains.
- Arithmetic is unsigned modulo 2^16. All flags derive from the full 16-bit result; none come from partial results.

## Timing
- Reset values (held while `rst_n = 0`):
  - state IDLE, `in_ready = 1`, `out_valid = 0`;
  - `diff = 16'h0000`, `borrow = 0`, `zr = 0`, `ng = 0`, `ovf = 0`;
  - counter 0, carry 0.
- Latency: operands accepted on edge E0 → `out_valid` high after edge E16, i.e. 16 cycles.
- Minimum throughput: one result per 18 cycles (accept, 16 shift, drain with `out_ready` already high at DONE).
- `in_ready` returns high the cycle after the draining edge.
- `rst_n` asserted mid-SHIFT or in DONE aborts the operation immediately. All outputs take reset values. The pending result is lost and never presented.
- `out_ready` high before `out_valid` has no effect. The handshake completes on the first edge both are high.

## Test plan
- Reset then `a=16'h0005`, `b=16'h0003` → after 16 cycles `diff=16'h0002`, `borrow=0`, `zr=0`, `ng=0`, `ovf=0`.
- `a=16'h0003`, `b=16'h0005` → `diff=16'hFFFE`, `borrow=1`, `ng=1`, `ovf=0`.
- `a=16'h8000`, `b=16'h0001` → `diff=16'h7FFF`, `ovf=1`, `ng=0`, `borrow=0`. Also `a=16'h7FFF`, `b=16'hFFFF` → `diff=16'h8000`, `ovf=1`, `borrow=1`.
- `a=b=16'h1234` → `diff=0`, `zr=1`, `borrow=0`. Hold `out_ready=0` for 5 cycles after `out_valid` → outputs stable, `in_ready=0` throughout. Then drain → `in_ready=1` next cycle.
- Start `a=16'hFFFF`, `b=16'h0001`, assert `rst_n=0` 8 cycles after acceptance → all outputs at reset values immediately, no `out_valid`. After release, `a=16'h0010`, `b=16'h0001` → `diff=16'h000F`.
- Back-to-back: `in_valid` held high with changing operands, `out_ready=1` → exactly one operation per 18 cycles, results match the golden `a-b` for 100 random pairs.
